// File: rtl/instruction_fetch_unit.sv
// Four-phase fetch/decode/execute/increment sequencer with PC and IR.
// Define FETCH_HALT_EN to make opcode 8'hFF park the unit in HALT.
module instruction_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clock,
  input  logic       input_clear_n,
  input  logic       input_clock_enable,
  input  logic [7:0] input_mem_data,
  input  logic       input_mem_ready,
  input  logic       input_jump,
  input  logic [7:0] input_jump_addr,
  output logic [7:0] output_mem_addr,
  output logic       output_mem_req,
  output logic [7:0] output_ir,
  output logic [7:0] output_pc,
  output logic       output_fetch,
  output logic       output_decode,
  output logic       output_execute,
  output logic       output_increment,
  output logic       output_halt
);

`ifdef FETCH_HALT_EN
  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_INCR,
    S_HALT
  } state_e;
`else
  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_INCR
  } state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       jp_q, jp_d;
  logic [7:0] jt_q, jt_d;

  always_ff @(posedge clock or negedge input_clear_n) begin
    if (!input_clear_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      jp_q    <= 1'b0;
      jt_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      jp_q    <= jp_d;
      jt_q    <= jt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    jp_d    = jp_q;
    jt_d    = jt_q;
    unique case (state_q)
      S_FETCH: begin
        if (input_clock_enable && input_mem_ready) begin
          ir_d    = input_mem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (input_clock_enable) begin
          state_d = S_EXECUTE;
`ifdef FETCH_HALT_EN
          if (ir_q == 8'hFF) state_d = S_HALT;
`endif
        end
      end
      S_EXECUTE: begin
        if (input_clock_enable) begin
          if (input_jump) begin
            jp_d = 1'b1;
            jt_d = input_jump_addr;
          end
          state_d = S_INCR;
        end
      end
      S_INCR: begin
        if (input_clock_enable) begin
          pc_d    = jp_q ? jt_q : pc_q + 8'd1;
          jp_d    = 1'b0;
          state_d = S_FETCH;
        end
      end
`ifdef FETCH_HALT_EN
      // Only reset leaves HALT.
      S_HALT: ;
`endif
    endcase
  end

  assign output_pc        = pc_q;
  assign output_mem_addr  = pc_q;
  assign output_ir        = ir_q;
  assign output_fetch     = (state_q == S_FETCH);
  assign output_decode    = (state_q == S_DECODE);
  assign output_execute   = (state_q == S_EXECUTE);
  assign output_increment = (state_q == S_INCR);
  assign output_mem_req   = (state_q == S_FETCH);
`ifdef FETCH_HALT_EN
  assign output_halt      = (state_q == S_HALT);
`else
  assign output_halt      = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed vector bench for instruction_fetch_unit (default build).
module tb_instruction_fetch_unit;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       ce;
  logic [7:0] mdata;
  logic       rdy;
  logic       jmp;
  logic [7:0] jaddr;
  logic [7:0] maddr;
  logic       mreq;
  logic [7:0] ir;
  logic [7:0] pc;
  logic       f, d, e, i, halt;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] PF = 4'b1000;
  localparam logic [3:0] PD = 4'b0100;
  localparam logic [3:0] PE = 4'b0010;
  localparam logic [3:0] PI = 4'b0001;

  typedef struct {
    logic       ce;
    logic       rdy;
    logic [7:0] data;
    logic       jmp;
    logic [7:0] ja;
    logic [3:0] ph;
    logic [7:0] pc;
    logic [7:0] ir;
  } vec_t;

  vec_t vq[$];

  instruction_fetch_unit #(.RESET_PC(8'h00)) dut (
    .clock(clock),
    .input_clear_n(rst_n),
    .input_clock_enable(ce),
    .input_mem_data(mdata),
    .input_mem_ready(rdy),
    .input_jump(jmp),
    .input_jump_addr(jaddr),
    .output_mem_addr(maddr),
    .output_mem_req(mreq),
    .output_ir(ir),
    .output_pc(pc),
    .output_fetch(f),
    .output_decode(d),
    .output_execute(e),
    .output_increment(i),
    .output_halt(halt)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic c, logic r, logic [7:0] dt,
                              logic j, logic [7:0] ja,
                              logic [3:0] ph, logic [7:0] p,
                              logic [7:0] x);
    vec_t v;
    v.ce = c; v.rdy = r; v.data = dt; v.jmp = j; v.ja = ja;
    v.ph = ph; v.pc = p; v.ir = x;
    return v;
  endfunction

  task automatic chk(string nm, logic [3:0] ph, logic [7:0] p,
                     logic [7:0] x);
    logic [28:0] act, exp;
    act = {f, d, e, i, pc, ir, maddr, mreq, halt};
    exp = {ph, p, x, p, ph[3], 1'b0};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got strobes=%b pc=%h ir=%h addr=%h req=%b halt=%b, want strobes=%b pc=%h ir=%h addr=%h req=%b halt=0",
               nm, {f, d, e, i}, pc, ir, maddr, mreq, halt,
               ph, p, x, p, ph[3]);
    end
  endtask

  task automatic drive(logic c, logic r, logic [7:0] dt, logic j,
                       logic [7:0] ja);
    ce = c; rdy = r; mdata = dt; jmp = j; jaddr = ja;
  endtask

  task automatic step(string nm, logic [3:0] ph, logic [7:0] p,
                      logic [7:0] x);
    @(posedge clock);
    #1;
    chk(nm, ph, p, x);
  endtask

  task automatic pulse_reset(string nm);
    #2 rst_n = 1'b0;
    #1 chk(nm, PF, 8'h00, 8'h00);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // basic flow
    vq.push_back(mk(1, 1, 8'h40, 0, 0, PD, 8'h00, 8'h40));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PE, 8'h00, 8'h40));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PI, 8'h00, 8'h40));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PF, 8'h01, 8'h40));
    vq.push_back(mk(1, 1, 8'h10, 0, 0, PD, 8'h01, 8'h10));
    vq.push_back(mk(1, 1, 8'h00, 0, 0, PE, 8'h01, 8'h10));
    vq.push_back(mk(1, 1, 8'h00, 0, 0, PI, 8'h01, 8'h10));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PF, 8'h02, 8'h10));
    // three stall cycles
    vq.push_back(mk(1, 0, 8'h99, 0, 0, PF, 8'h02, 8'h10));
    vq.push_back(mk(1, 0, 8'h99, 0, 0, PF, 8'h02, 8'h10));
    vq.push_back(mk(1, 0, 8'h99, 0, 0, PF, 8'h02, 8'h10));
    vq.push_back(mk(1, 1, 8'h22, 0, 0, PD, 8'h02, 8'h22));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PE, 8'h02, 8'h22));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PI, 8'h02, 8'h22));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PF, 8'h03, 8'h22));
    // jump in DECODE ignored
    vq.push_back(mk(1, 1, 8'h33, 0, 0, PD, 8'h03, 8'h33));
    vq.push_back(mk(1, 1, 8'h99, 1, 8'h80, PE, 8'h03, 8'h33));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PI, 8'h03, 8'h33));
    vq.push_back(mk(1, 0, 8'h00, 1, 8'h81, PF, 8'h04, 8'h33));
    // jump in EXECUTE taken
    vq.push_back(mk(1, 1, 8'h44, 0, 0, PD, 8'h04, 8'h44));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PE, 8'h04, 8'h44));
    vq.push_back(mk(1, 0, 8'h00, 1, 8'h20, PI, 8'h04, 8'h44));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PF, 8'h20, 8'h44));
    // jump to self
    vq.push_back(mk(1, 1, 8'h55, 0, 0, PD, 8'h20, 8'h55));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PE, 8'h20, 8'h55));
    vq.push_back(mk(1, 0, 8'h00, 1, 8'h20, PI, 8'h20, 8'h55));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PF, 8'h20, 8'h55));
    // clock enable low in DECODE
    vq.push_back(mk(1, 1, 8'h66, 0, 0, PD, 8'h20, 8'h66));
    vq.push_back(mk(0, 1, 8'h77, 1, 8'h90, PD, 8'h20, 8'h66));
    vq.push_back(mk(0, 1, 8'h77, 1, 8'h90, PD, 8'h20, 8'h66));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PE, 8'h20, 8'h66));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PI, 8'h20, 8'h66));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PF, 8'h21, 8'h66));
    // ready with enable low ignored
    vq.push_back(mk(0, 1, 8'h77, 0, 0, PF, 8'h21, 8'h66));
    vq.push_back(mk(1, 1, 8'h88, 0, 0, PD, 8'h21, 8'h88));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PE, 8'h21, 8'h88));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PI, 8'h21, 8'h88));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PF, 8'h22, 8'h88));
    // 8'hFF is ordinary in the default build
    vq.push_back(mk(1, 1, 8'hFF, 0, 0, PD, 8'h22, 8'hFF));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PE, 8'h22, 8'hFF));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PI, 8'h22, 8'hFF));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PF, 8'h23, 8'hFF));
    // wrap FF -> 00
    vq.push_back(mk(1, 1, 8'h01, 0, 0, PD, 8'h23, 8'h01));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PE, 8'h23, 8'h01));
    vq.push_back(mk(1, 0, 8'h00, 1, 8'hFF, PI, 8'h23, 8'h01));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PF, 8'hFF, 8'h01));
    vq.push_back(mk(1, 1, 8'h02, 0, 0, PD, 8'hFF, 8'h02));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PE, 8'hFF, 8'h02));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PI, 8'hFF, 8'h02));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PF, 8'h00, 8'h02));
    // move to 8'h30
    vq.push_back(mk(1, 1, 8'h03, 0, 0, PD, 8'h00, 8'h03));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PE, 8'h00, 8'h03));
    vq.push_back(mk(1, 0, 8'h00, 1, 8'h30, PI, 8'h00, 8'h03));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, PF, 8'h30, 8'h03));

    drive(1, 0, 8'h00, 0, 8'h00);
    rst_n = 1'b0;
    #12;
    chk("reset", PF, 8'h00, 8'h00);
    @(negedge clock);
    rst_n = 1'b1;
    drive(vq[0].ce, vq[0].rdy, vq[0].data, vq[0].jmp, vq[0].ja);

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].ce, vq[k].rdy, vq[k].data, vq[k].jmp, vq[k].ja);
      step($sformatf("vec%0d", k), vq[k].ph, vq[k].pc, vq[k].ir);
    end

    // reset in EXECUTE at PC 8'h30
    drive(1, 1, 8'hAB, 0, 8'h00);
    step("pre_rst_d", PD, 8'h30, 8'hAB);
    drive(1, 0, 8'h00, 0, 8'h00);
    step("pre_rst_e", PE, 8'h30, 8'hAB);
    drive(1, 1, 8'hC3, 1, 8'h55);
    pulse_reset("rst_exec");
    jmp = 1'b0;
    step("first_edge", PD, 8'h00, 8'hC3);
    drive(1, 0, 8'h00, 0, 8'h00);
    step("post_rst_e", PE, 8'h00, 8'hC3);
    // latch a jump, then reset with it pending
    drive(1, 0, 8'h00, 1, 8'h77);
    step("pend_i", PI, 8'h00, 8'hC3);
    drive(1, 0, 8'h00, 0, 8'h00);
    pulse_reset("rst_incr");
    drive(1, 1, 8'h11, 0, 8'h00);
    step("clr_d", PD, 8'h00, 8'h11);
    drive(1, 0, 8'h00, 0, 8'h00);
    step("clr_e", PE, 8'h00, 8'h11);
    step("clr_i", PI, 8'h00, 8'h11);
    step("jp_dropped", PF, 8'h01, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
